// File: rtl/mux_chk_pkg.sv
// Shared definitions for the mux pattern checker: FSM encoding, last vector index
// and the golden 2:1 mux model.
`timescale 1ns/1ps
package mux_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] VEC_LAST = 3'd7;

    function automatic logic mux_exp(input logic in0, input logic in1, input logic sel);
        return sel ? in1 : in0;
    endfunction

endpackage

// File: rtl/mux_chk_cmp.sv
// Combinational compare of all mux outputs against one expected bit; returns the
// per-instance mismatch vector and its population count.
`timescale 1ns/1ps
module mux_chk_cmp
    import mux_chk_pkg::*;
#(
    parameter int N_DUT = 3,
    parameter int POP_W = 2
) (
    input  logic [N_DUT-1:0] i_dut_out,
    input  logic             i_exp,
    output logic [N_DUT-1:0] o_mis,
    output logic [POP_W-1:0] o_pop
);

    assign o_mis = i_dut_out ^ {N_DUT{i_exp}};

    // NOTE: o_pop is given a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_pop = '0;
        for (int k = 0; k < N_DUT; k++) begin
            o_pop = o_pop + POP_W'(o_mis[k]);
        end
    end

endmodule

// File: rtl/mux_pattern_checker.sv
// Exhaustive stimulus generator and checker for the 2:1 mux variants: walks {in0,in1,sel}
// through 000..111, dwells, samples every mux output and accumulates sticky results.
`timescale 1ns/1ps
module mux_pattern_checker
    import mux_chk_pkg::*;
#(
    parameter int DWELL = 50,
    parameter int N_DUT = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in0,
    output logic             in1,
    output logic             sel,
    input  logic [N_DUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N_DUT-1:0] err_mask,
    output logic [2:0]       vec_idx
);

    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int POP_W = $clog2(N_DUT + 1);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [DW_W-1:0]  DWELL_LOAD = DW_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DW_W-1:0]    r_dwell;
    logic [2:0]         r_vec;
    logic               r_in0;
    logic               r_in1;
    logic               r_sel;
    logic               r_pass;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [N_DUT-1:0]   r_err_mask;

    logic               w_exp;
    logic [N_DUT-1:0]   w_mis;
    logic [POP_W-1:0]   w_pop;
    logic [SUM_W-1:0]   w_sum;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]         w_vec_nxt;

    assign w_exp = mux_exp(r_in0, r_in1, r_sel);

    mux_chk_cmp #(
        .N_DUT (N_DUT),
        .POP_W (POP_W)
    ) u_cmp (
        .i_dut_out (dut_out),
        .i_exp     (w_exp),
        .o_mis     (w_mis),
        .o_pop     (w_pop)
    );

    // Sum is computed one carry wider so the clamp sees overflow instead of a wrap.
    assign w_sum     = SUM_W'(r_err_cnt) + SUM_W'(w_pop);
    assign w_cnt_nxt = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
    assign w_vec_nxt = r_vec + 3'd1;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_nxt = SETTLE;
            SETTLE:     if (r_dwell == '0) w_state_nxt = SAMPLE;
            SAMPLE:     w_state_nxt = (r_vec == VEC_LAST) ? DONE : SETTLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwell    <= '0;
            r_vec      <= '0;
            r_in0      <= 1'b0;
            r_in1      <= 1'b0;
            r_sel      <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_err_mask <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_dwell              <= DWELL_LOAD;
                        r_vec                <= '0;
                        {r_in0, r_in1, r_sel} <= 3'b000;
                        r_pass               <= 1'b0;
                        r_err_cnt            <= '0;
                        r_err_mask           <= '0;
                    end
                end
                SETTLE: begin
                    if (r_dwell != '0) r_dwell <= r_dwell - DW_W'(1);
                end
                SAMPLE: begin
                    r_err_mask <= r_err_mask | w_mis;
                    r_err_cnt  <= w_cnt_nxt;
                    if (r_vec == VEC_LAST) begin
                        r_vec                 <= '0;
                        {r_in0, r_in1, r_sel} <= 3'b000;
                        r_pass                <= (w_cnt_nxt == '0);
                    end else begin
                        r_vec                 <= w_vec_nxt;
                        {r_in0, r_in1, r_sel} <= w_vec_nxt;
                        r_dwell               <= DWELL_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in0      = r_in0;
    assign in1      = r_in1;
    assign sel      = r_sel;
    assign busy     = (r_state == SETTLE) || (r_state == SAMPLE);
    assign done     = (r_state == DONE);
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign err_mask = r_err_mask;
    assign vec_idx  = r_vec;

endmodule

// File: tb/tb_mux_pattern_checker.sv
// Directed bench for mux_pattern_checker: clean, faulty, mid-run reset, ignored start,
// restart from DONE and counter saturation with hand-computed expectations.
`timescale 1ns/1ps
module tb_mux_pattern_checker;

    localparam int DWELL = 4;
    localparam int N_DUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_s = 1'b0;

    logic             in0, in1, sel, busy, done, pass;
    logic [7:0]       err_cnt;
    logic [N_DUT-1:0] err_mask, dut_out;
    logic [2:0]       vec_idx;

    logic             in0_s, in1_s, sel_s, busy_s, done_s, pass_s;
    logic [2:0]       err_cnt_s;
    logic [N_DUT-1:0] err_mask_s, dut_out_s;
    logic [2:0]       vec_idx_s;

    logic stuck1 = 1'b0;
    logic inv2   = 1'b0;
    logic m_if, m_case;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Three mux styles under test, with injectable faults on instances 1 and 2.
    always_comb begin
        if (sel) m_if = in1;
        else     m_if = in0;
    end
    always_comb begin
        case (sel)
            1'b0:    m_case = in0;
            default: m_case = in1;
        endcase
    end
    assign dut_out[0] = sel ? in1 : in0;
    assign dut_out[1] = stuck1 ? 1'b0 : m_if;
    assign dut_out[2] = inv2 ? ~m_case : m_case;
    assign dut_out_s  = ~{N_DUT{sel_s ? in1_s : in0_s}};

    mux_pattern_checker #(.DWELL(DWELL), .N_DUT(N_DUT), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .in0(in0), .in1(in1), .sel(sel), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .err_mask(err_mask), .vec_idx(vec_idx)
    );

    mux_pattern_checker #(.DWELL(DWELL), .N_DUT(N_DUT), .CNT_W(3)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start_s),
        .in0(in0_s), .in1(in1_s), .sel(sel_s), .dut_out(dut_out_s),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_cnt(err_cnt_s), .err_mask(err_mask_s), .vec_idx(vec_idx_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":in"},    32'({in0, in1, sel}), 32'd0);
        check({tag, ":busy"},  32'(busy),     32'd0);
        check({tag, ":done"},  32'(done),     32'd0);
        check({tag, ":pass"},  32'(pass),     32'd0);
        check({tag, ":cnt"},   32'(err_cnt),  32'd0);
        check({tag, ":mask"},  32'(err_mask), 32'd0);
        check({tag, ":vec"},   32'(vec_idx),  32'd0);
    endtask

    // Called at a negedge; pulses start and follows the whole run to DONE.
    task automatic run_check(input string name, input int exp_cnt,
                             input logic [2:0] exp_mask, input bit poke5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, ":go_busy"}, 32'(busy),     32'd1);
        check({name, ":go_done"}, 32'(done),     32'd0);
        check({name, ":go_pass"}, 32'(pass),     32'd0);
        check({name, ":go_cnt"},  32'(err_cnt),  32'd0);
        check({name, ":go_mask"}, 32'(err_mask), 32'd0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s:vec%0d", name, k), 32'(vec_idx), 32'(k));
            check($sformatf("%s:stim%0d", name, k), 32'({in0, in1, sel}), 32'(k));
            if (poke5 && k == 5) start = 1'b1;
            repeat ((k < 7) ? DWELL + 1 : DWELL) begin
                tick();
                start = 1'b0;
            end
        end
        check({name, ":pre_done"}, 32'(done), 32'd0);
        check({name, ":pre_busy"}, 32'(busy), 32'd1);
        tick();
        check({name, ":done"},  32'(done),     32'd1);
        check({name, ":busy"},  32'(busy),     32'd0);
        check({name, ":pass"},  32'(pass),     32'(exp_cnt == 0));
        check({name, ":cnt"},   32'(err_cnt),  32'(exp_cnt));
        check({name, ":mask"},  32'(err_mask), 32'(exp_mask));
        check({name, ":vec"},   32'(vec_idx),  32'd0);
        check({name, ":stim"},  32'({in0, in1, sel}), 32'd0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        check("reset_sat:cnt", 32'(err_cnt_s), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle:busy", 32'(busy), 32'd0);

        run_check("clean", 0, 3'b000, 1'b0);
        stuck1 = 1'b1;
        run_check("stuck1", 4, 3'b010, 1'b0);
        inv2 = 1'b1;
        run_check("stuck1_inv2", 12, 3'b110, 1'b0);
        stuck1 = 1'b0;
        inv2   = 1'b0;
        run_check("poke5", 0, 3'b000, 1'b1);

        // Abort a faulty run at vector 3; nothing of it may survive.
        inv2  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3 * (DWELL + 1)) tick();
        check("abort:vec_pre", 32'(vec_idx), 32'd3);
        check("abort:cnt_pre", 32'(err_cnt), 32'd3);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        tick();
        rst  = 1'b0;
        inv2 = 1'b0;
        tick();
        check_all_zero("abort_idle");
        run_check("post_rst", 0, 3'b000, 1'b0);

        // Narrow counter: 3 mismatches per vector, 24 in total, clamps at 7.
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        repeat (2 * (DWELL + 1)) tick();
        check("sat:cnt_2vec", 32'(err_cnt_s), 32'd6);
        repeat (DWELL + 1) tick();
        check("sat:cnt_3vec", 32'(err_cnt_s), 32'd7);
        repeat (5 * (DWELL + 1)) tick();
        check("sat:done", 32'(done_s),     32'd1);
        check("sat:cnt",  32'(err_cnt_s),  32'd7);
        check("sat:mask", 32'(err_mask_s), 32'd7);
        check("sat:pass", 32'(pass_s),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
